regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised successor to the pipeline register file. It provides NUM_RD combinational read ports and one synchronous write port, and keeps the rt/rd destination select. It adds optional write-to-read bypass, a synchronous clear of all registers, and a per-register pending-write scoreboard. The block sits in the ID stage. Hazard/stall logic uses its busy flags and issue-ready output instead of comparing register numbers across stages.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
CNT_W, 2, width of the per-register pending-write counter; max in-flight writers = 2**CNT_W-1

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
raddr  in  NUM_RD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data, combinational
rbusy  out  NUM_RD  per port: register has a pending writer (count != 0)
we  in  1  write enable (WB stage)
wdst_sel  in  1  1 = write to wa_rt, 0 = write to wa_rd
wa_rt  in  ADDR_W  rt destination index
wa_rd  in  ADDR_W  rd destination index
wdata  in  DATA_W  write data
iss_valid  in  1  an instruction with a register destination issues this cycle
iss_addr  in  ADDR_W  destination index of the issuing instruction
iss_ready  out  1  issue is accepted (counter of iss_addr not saturated)
wb_err  out  1  sticky: a writeback arrived for a register whose count was 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. No asynchronous paths.
- Write address: waddr = wdst_sel ? wa_rt : wa_rd.
- Write: on the rising edge with we=1 and waddr!=0, rf[waddr] <= wdata. Writes to index 0 are dropped.
- Read port k:
  - index 0 -> 0.
  - Else, if BYPASS=1 and we=1 and waddr==raddr_k -> wdata.
  - Else -> rf[raddr_k].
  - Zero-cycle latency.
- Reset (rst=1 at an edge):
  - All rf entries, all counters and wb_err clear to 0 in that single cycle.
  - we and iss_valid are ignored in that cycle.
  - After reset every rdata = 0 (except a bypass hit), rbusy = 0 and iss_ready = 1.
  - Reset asserted mid-sequence discards all pending counts.
- Scoreboard: cnt[r] is CNT_W bits, r in 1..2**ADDR_W-1. cnt[0] is constant 0, so index 0 is never busy.
  - Issue event: iss_valid & iss_ready & iss_addr!=0.
  - Retire event: we & waddr!=0.
  - Per register, per edge:
    - issue only -> cnt+1.
    - retire only -> cnt-1 if cnt>0; if cnt==0, cnt stays 0 and wb_err <= 1.
    - issue and retire on the same register -> cnt unchanged. This counts as legal even when cnt==0: the retire belongs to an older writer.
  - Issue and retire on different registers update both independently.
- iss_ready = (iss_addr==0) | (cnt[iss_addr] != 2**CNT_W-1). It is combinational and does not depend on same-cycle retire.
  - Saturated issue is not accepted; cnt is unchanged.
  - Upstream must hold iss_valid and stall.
- rbusy_k = (cnt[raddr_k] != 0). It is the pre-edge value and ignores a same-cycle retire. Hazard logic combines rbusy with bypass.
- wb_err clears only on reset.
- No initial blocks for functional state; reset is the only initialiser.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ZERO = 0.
  - Default DATA_W/ADDR_W constants, shared with the decode and hazard units.
  - The write-destination select encoding, WDST_RD = 0 and WDST_RT = 1, shared with the control unit.
- One sub-module: regfile_scoreboard. It holds the counter array, the iss_ready/rbusy logic and wb_err. The storage and read/bypass muxes stay in regfile_sb.

Test Plan:
1. Reset then read: rst=1 for 1 cycle; raddr={3,7} -> rdata={0,0}, rbusy=0, iss_ready=1, wb_err=0.
2. Write destination select: we=1, wdst_sel=1, wa_rt=5, wa_rd=9, wdata=32'hDEADBEEF -> next cycle r5=DEADBEEF, r9=0. Then wdst_sel=0 -> r9 written. Writing wdata=32'h1234 with waddr=0 -> r0 still reads 0.
3. Bypass: in one cycle we=1, waddr=4, wdata=32'hA5A5A5A5, raddr0=4 -> rdata0=A5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> old value 0.
4. Scoreboard count and saturation (CNT_W=2): issue to r6 three times -> rbusy=1 and iss_ready=0 for iss_addr=6. A fourth issue is rejected; count stays 3. Three retires -> rbusy drops after the third.
5. Simultaneous issue+retire: cnt[8]=1; issue r8 and write r8 in the same cycle -> cnt stays 1 and rbusy stays 1. Also run with cnt[8]=0 -> cnt stays 0 and wb_err stays 0.
6. Spurious retire and mid-operation reset: write r10 with cnt=0 -> wb_err=1 and sticky. With cnt[2]=2, assert rst -> all counts 0, wb_err=0, r2 reads 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry defaults and the
// write-destination select encoding used by decode, hazard and control units.
package cpu_pkg;

  // Default datapath geometry, shared by decode, hazard and register file
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register index; reads as zero, writes are dropped
  localparam int REG_ZERO = 0;

  // Write-destination select as produced by the control unit
  typedef enum logic {
    WDST_RD = 1'b0,
    WDST_RT = 1'b1
  } wdst_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard. Each register has a small counter of
// in-flight writers: issue increments it, writeback decrements it. Hazard
// logic reads busy flags and issue readiness rather than comparing indices.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     retire_valid,
  input  logic [ADDR_W-1:0]        retire_addr,
  output logic                     wb_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic             wb_err_q;
  logic             wb_err_d;
  logic             issue_evt;
  logic             retire_evt;

  // A saturated counter refuses further issue; index 0 never tracks writers
  assign iss_ready  = (iss_addr == ZERO_IDX) || (cnt_q[iss_addr] != CNT_MAX);
  assign issue_evt  = iss_valid && iss_ready && (iss_addr != ZERO_IDX);
  assign retire_evt = retire_valid && (retire_addr != ZERO_IDX);
  assign wb_err     = wb_err_q;

  // Busy is the pre-edge count; a same-cycle writeback is covered by bypass
  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign rbusy[k] = (cnt_q[raddr[k*ADDR_W +: ADDR_W]] != '0);
  end

  // Next counter values: issue and retire on one register cancel out, since
  // the retiring write belongs to an older writer than the one issuing now
  always_comb begin
    wb_err_d = wb_err_q;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < DEPTH; r++) begin
      if (issue_evt && (iss_addr == ADDR_W'(r)) &&
          !(retire_evt && (retire_addr == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (retire_evt && (retire_addr == ADDR_W'(r)) &&
                   !(issue_evt && (iss_addr == ADDR_W'(r)))) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end else begin
          wb_err_d = 1'b1;
        end
      end
    end
    cnt_d[0] = '0;
  end

  // Counter and sticky error state; reset discards every pending count
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= '0;
      end
      wb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file with NUM_RD combinational read ports, one write port
// selecting rt/rd as destination, optional write-to-read bypass, synchronous
// clear and a pending-write scoreboard for hazard detection.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic                     wdst_sel,
  input  logic [ADDR_W-1:0]        wa_rt,
  input  logic [ADDR_W-1:0]        wa_rd,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic                     wb_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic [ADDR_W-1:0] waddr;
  logic              wr_en;

  // Destination index and effective write enable; writes to r0 are dropped
  assign waddr = (wdst_sel_e'(wdst_sel) == WDST_RT) ? wa_rt : wa_rd;
  assign wr_en = we && (waddr != ZERO_IDX);

  // Next register contents: one entry updated on a write, r0 pinned at zero
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      rf_d[r] = rf_q[r];
    end
    if (wr_en) begin
      rf_d[waddr] = wdata;
    end
    rf_d[0] = '0;
  end

  // Register storage with synchronous clear of every entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  // Read ports: zero register, then same-cycle bypass, then stored value
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp_hit;
    assign ra      = raddr[k*ADDR_W +: ADDR_W];
    assign byp_hit = (BYPASS != 0) && wr_en && (waddr == ra);
    assign rdata[k*DATA_W +: DATA_W] = (ra == ZERO_IDX) ? '0 :
                                       byp_hit          ? wdata :
                                                          rf_q[ra];
  end

  // Pending-writer tracking; a retire is any real register writeback
  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .CNT_W  (CNT_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .raddr        (raddr),
    .rbusy        (rbusy),
    .iss_valid    (iss_valid),
    .iss_addr     (iss_addr),
    .iss_ready    (iss_ready),
    .retire_valid (wr_en),
    .retire_addr  (waddr),
    .wb_err       (wb_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. Two instances share stimulus: one with
// bypass enabled and one without. Expected values are queued when stimulus is
// applied and popped when the corresponding output is sampled.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata, rdata_nb;
  logic [1:0]    rbusy, rbusy_nb;
  logic          we, wdst_sel;
  logic [AW-1:0] wa_rt, wa_rd, iss_addr;
  logic [DW-1:0] wdata;
  logic          iss_valid;
  logic          iss_ready, iss_ready_nb;
  logic          wb_err, wb_err_nb;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .wdst_sel(wdst_sel), .wa_rt(wa_rt), .wa_rd(wa_rd), .wdata(wdata),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready), .wb_err(wb_err)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0), .CNT_W(2)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .wdst_sel(wdst_sel), .wa_rt(wa_rt), .wa_rd(wa_rd), .wdata(wdata),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready_nb), .wb_err(wb_err_nb)
  );

  // Drive everything quiet; raddr is left alone
  task automatic drive_idle();
    rst = 1'b0; we = 1'b0; wdst_sel = 1'b0; wa_rt = '0; wa_rd = '0;
    wdata = '0; iss_valid = 1'b0; iss_addr = '0;
  endtask

  // Write through rd with a matching issue so the scoreboard stays balanced
  task automatic drive_write_matched(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wdst_sel = 1'b0; wa_rd = a; wa_rt = '0; wdata = d;
    iss_valid = 1'b1; iss_addr = a;
  endtask

  task automatic test_reset();
    @(negedge clk);
    drive_idle(); rst = 1'b1; raddr = {5'd7, 5'd3}; iss_addr = 5'd6;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({32'h0, 32'h0}); exp_q.push_back(64'h0);
    exp_q.push_back(64'h1); exp_q.push_back(64'h0);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({62'h0, rbusy} !== exp_v) begin mismatched++; $display("[TB] FAIL reset_rbusy: got %b expected %0h", rbusy, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, iss_ready} !== exp_v) begin mismatched++; $display("[TB] FAIL reset_iss_ready: got %b expected %0h", iss_ready, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL reset_wb_err: got %b expected %0h", wb_err, exp_v); end
  endtask

  task automatic test_write_select();
    // rt selected: r5 written, r9 untouched
    @(negedge clk);
    we = 1'b1; wdst_sel = 1'b1; wa_rt = 5'd5; wa_rd = 5'd9; wdata = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_addr = 5'd5; raddr = {5'd9, 5'd5};
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    @(negedge clk);
    drive_idle();
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL wsel_rt: got %h expected %h", rdata, exp_v); end
    // rd selected: r9 written, r5 keeps its value
    drive_write_matched(5'd9, 32'hCAFEF00D); wa_rt = 5'd5;
    exp_q.push_back({32'hCAFEF00D, 32'hDEADBEEF});
    @(negedge clk);
    drive_idle();
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL wsel_rd: got %h expected %h", rdata, exp_v); end
    // write to r0 is dropped and never bypassed
    we = 1'b1; wdst_sel = 1'b0; wa_rd = 5'd0; wdata = 32'h1234; raddr = {5'd9, 5'd0};
    exp_q.push_back({32'hCAFEF00D, 32'h0}); exp_q.push_back({32'hCAFEF00D, 32'h0});
    exp_q.push_back(64'h0);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL r0_bypass: got %h expected %h", rdata, exp_v); end
    @(negedge clk);
    drive_idle();
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL r0_write: got %h expected %h", rdata, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL wsel_wb_err: got %b expected %0h", wb_err, exp_v); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    drive_write_matched(5'd4, 32'hA5A5A5A5); raddr = {5'd5, 5'd4};
    exp_q.push_back({32'hDEADBEEF, 32'hA5A5A5A5});
    exp_q.push_back({32'hDEADBEEF, 32'h0});
    exp_q.push_back({32'hDEADBEEF, 32'hA5A5A5A5});
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL bypass_on: got %h expected %h", rdata, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if (rdata_nb !== exp_v) begin mismatched++; $display("[TB] FAIL bypass_off: got %h expected %h", rdata_nb, exp_v); end
    @(negedge clk);
    drive_idle();
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata_nb !== exp_v) begin mismatched++; $display("[TB] FAIL bypass_off_after: got %h expected %h", rdata_nb, exp_v); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    drive_idle(); raddr = {5'd0, 5'd6}; iss_valid = 1'b1; iss_addr = 5'd6;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(64'h1);
      #1;
      exp_v = exp_q.pop_front(); compared++;
      if ({63'h0, iss_ready} !== exp_v) begin mismatched++; $display("[TB] FAIL sat_ready_%0d: got %b expected %0h", i, iss_ready, exp_v); end
      @(negedge clk);
    end
    // fourth issue is refused
    exp_q.push_back(64'h0); exp_q.push_back(64'h1);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, iss_ready} !== exp_v) begin mismatched++; $display("[TB] FAIL sat_full: got %b expected %0h", iss_ready, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL sat_busy: got %b expected %0h", rbusy[0], exp_v); end
    @(negedge clk);
    // three retires; busy reflects the pre-edge count throughout
    for (int i = 0; i < 3; i++) begin
      drive_idle(); iss_addr = 5'd6; we = 1'b1; wa_rd = 5'd6; wdata = DW'(i + 100);
      exp_q.push_back(64'h1);
      #1;
      exp_v = exp_q.pop_front(); compared++;
      if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL retire_busy_%0d: got %b expected %0h", i, rbusy[0], exp_v); end
      @(negedge clk);
    end
    drive_idle(); iss_addr = 5'd6;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h1);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL retire_idle: got %b expected %0h", rbusy[0], exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL retire_wb_err: got %b expected %0h", wb_err, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, iss_ready} !== exp_v) begin mismatched++; $display("[TB] FAIL retire_ready: got %b expected %0h", iss_ready, exp_v); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    drive_idle(); raddr = {5'd0, 5'd8}; iss_valid = 1'b1; iss_addr = 5'd8;
    @(negedge clk);
    drive_write_matched(5'd8, 32'h88);
    @(negedge clk);
    drive_idle();
    exp_q.push_back(64'h1);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL same_busy_cnt1: got %b expected %0h", rbusy[0], exp_v); end
    we = 1'b1; wa_rd = 5'd8; wdata = 32'h89;
    @(negedge clk);
    drive_idle();
    exp_q.push_back(64'h0);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL same_drain: got %b expected %0h", rbusy[0], exp_v); end
    // issue plus retire with an empty counter is legal
    drive_write_matched(5'd8, 32'h8A);
    @(negedge clk);
    drive_idle();
    exp_q.push_back({62'h0, 1'b0, 1'b0});
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({62'h0, wb_err, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL same_cnt0: got err=%b busy=%b expected %0h", wb_err, rbusy[0], exp_v); end
    // different registers update independently
    iss_valid = 1'b1; iss_addr = 5'd12;
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_addr = 5'd11; we = 1'b1; wa_rd = 5'd12; wdata = 32'hC;
    @(negedge clk);
    drive_idle(); raddr = {5'd12, 5'd11};
    exp_q.push_back({61'h0, 1'b0, 2'b01});
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({61'h0, wb_err, rbusy} !== exp_v) begin mismatched++; $display("[TB] FAIL diff_regs: got err=%b busy=%b expected %0h", wb_err, rbusy, exp_v); end
  endtask

  task automatic test_spurious_and_reset();
    @(negedge clk);
    drive_idle(); we = 1'b1; wa_rd = 5'd10; wdata = 32'h10;
    @(negedge clk);
    drive_idle();
    exp_q.push_back(64'h1); exp_q.push_back(64'h1);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL spurious_err: got %b expected %0h", wb_err, exp_v); end
    drive_write_matched(5'd2, 32'h22);
    @(negedge clk);
    drive_idle(); iss_valid = 1'b1; iss_addr = 5'd2;
    @(negedge clk);
    @(negedge clk);
    drive_idle(); raddr = {5'd3, 5'd2};
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL sticky_err: got %b expected %0h", wb_err, exp_v); end
    exp_q.push_back({32'h0, 32'h22}); exp_q.push_back(64'h1);
    exp_v = exp_q.pop_front(); compared++;
    if (rdata[31:0] !== exp_v[31:0]) begin mismatched++; $display("[TB] FAIL pre_rst_r2: got %h expected %h", rdata[31:0], exp_v[31:0]); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, rbusy[0]} !== exp_v) begin mismatched++; $display("[TB] FAIL pre_rst_busy: got %b expected %0h", rbusy[0], exp_v); end
    // reset with write and issue asserted: both ignored
    rst = 1'b1; we = 1'b1; wa_rd = 5'd2; wdata = 32'h99; iss_valid = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    drive_idle(); iss_addr = 5'd2;
    exp_q.push_back({32'h0, 32'h0}); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h1);
    #1;
    exp_v = exp_q.pop_front(); compared++;
    if (rdata !== exp_v) begin mismatched++; $display("[TB] FAIL post_rst_rdata: got %h expected %h", rdata, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({62'h0, rbusy} !== exp_v) begin mismatched++; $display("[TB] FAIL post_rst_busy: got %b expected %0h", rbusy, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, wb_err} !== exp_v) begin mismatched++; $display("[TB] FAIL post_rst_err: got %b expected %0h", wb_err, exp_v); end
    exp_v = exp_q.pop_front(); compared++;
    if ({63'h0, iss_ready} !== exp_v) begin mismatched++; $display("[TB] FAIL post_rst_ready: got %b expected %0h", iss_ready, exp_v); end
  endtask

  // Run every scenario in order, then report
  initial begin
    drive_idle();
    raddr = '0;
    test_reset();
    test_write_select();
    test_bypass();
    test_saturation();
    test_same_cycle();
    test_spurious_and_reset();
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
